id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline, directly downstream of the register file.
- Captures register-file read data, the sign-extended immediate, register addresses and decoded control for the EX stage.
- Bypasses same-cycle writeback data past the register file.
- Detects load-use hazards: stalls PC and IF/ID and inserts a bubble.
- Squashes the stage on branch flush and keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- IFID_Rs  in  REG_AW  rs field of instruction in ID
- IFID_Rt  in  REG_AW  rt field of instruction in ID
- IFID_Rd  in  REG_AW  rd field of instruction in ID
- ReadData1  in  DATA_W  register-file port 1 data (rs)
- ReadData2  in  DATA_W  register-file port 2 data (rt)
- SignExtImm  in  DATA_W  sign-extended immediate
- RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, RegDst_in  in  1 each  decoded control
- ALUOp_in  in  4  decoded ALU operation
- WB_RegWrite  in  1  writeback stage write enable (same signals that drive the register file)
- WB_WriteReg  in  REG_AW  writeback destination register
- WB_WriteData  in  DATA_W  writeback data
- Flush  in  1  squash instruction entering EX (taken branch/jump)
- Stall  out  1  combinational load-use hazard indication
- PCWrite  out  1  = ~Stall
- IFIDWrite  out  1  = ~Stall
- EX_Valid  out  1  EX slot holds a real instruction
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst  out  1 each  registered control
- EX_ALUOp  out  4  registered ALU op
- EX_A, EX_B  out  DATA_W  registered operands (after bypass)
- EX_Imm  out  DATA_W  registered immediate
- EX_Rs, EX_Rt, EX_Rd  out  REG_AW  registered register addresses (for forwarding unit)
- StallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset=0, asynchronous): every EX_* output, EX_Valid and StallCount = 0. Consequently Stall=0, PCWrite=1, IFIDWrite=1. Reset mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- Bypass (combinational):
  - A_next = WB_WriteData if WB_RegWrite=1, WB_WriteReg≠0 and WB_WriteReg==IFID_Rs; else ReadData1.
  - B_next uses the same rule with IFID_Rt and ReadData2.
  - Register 0 is never bypassed.
- Hazard (combinational):
  - Stall = EX_Valid & EX_MemRead & (EX_Rt≠0) & ((EX_Rt==IFID_Rs) | (EX_Rt==IFID_Rt)).
  - Compares both source fields regardless of instruction type (conservative stall is acceptable).
- Rising edge of Clk, priority order:
  1. Flush=1: bubble — all control outputs 0, EX_Valid=0, EX_A/EX_B/EX_Imm/addresses 0.
  2. Stall=1: same bubble; IF/ID and PC hold via IFIDWrite/PCWrite=0.
  3. Otherwise: capture A_next, B_next, SignExtImm, IFID_Rs/Rt/Rd and all *_in controls; EX_Valid=1.
- Flush and Stall together: flush wins; Stall still drives PCWrite/IFIDWrite low that cycle, and upstream flush logic overrides.
- Stall duration: exactly one cycle per load-use pair. After the bubble, EX_MemRead=0, so Stall deasserts and the held instruction is captured on the next edge.
- Latency: ID→EX is 1 cycle.
- StallCount increments on each rising edge where Stall=1 and Flush=0, and saturates at all-ones (no wrap).

Test Plan:
- Reset: drive reset=0 mid-run with EX_Valid=1 → all EX_* outputs 0, StallCount=0 asynchronously, and Stall=0 even when the ID inputs would otherwise hazard.
- Normal capture: Rs=8, Rt=9, ReadData1=1, ReadData2=2, Imm=0x10, ALUOp=2, RegWrite_in=1 → next edge EX_A=1, EX_B=2, EX_Imm=0x10, EX_ALUOp=2, EX_Valid=1, Stall=0.
- Bypass: WB_RegWrite=1, WB_WriteReg=8, WB_WriteData=0xDEAD, IFID_Rs=8, ReadData1=1 → EX_A=0xDEAD. Repeat with WB_WriteReg=0, IFID_Rs=0 → EX_A=ReadData1.
- Load-use: lw into $t2 captured (EX_MemRead=1, EX_Rt=10), then IFID_Rs=10 → Stall=1, PCWrite=0, IFIDWrite=0. Next edge: bubble (EX_Valid=0), StallCount=1. Following edge: instruction captured with Stall=0.
- Flush: Flush=1 with a valid ID instruction and a concurrent load-use hazard → next edge EX_Valid=0 and all controls 0; StallCount unchanged.
- Saturation: force 2^CNT_W+3 stall cycles → StallCount holds at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 5-stage MIPS pipeline, sitting directly
// after the register file. It captures operands, immediate, register
// addresses and decoded control for EX, bypasses same-cycle writeback data
// around the register file, detects load-use hazards (stalling PC and IF/ID
// while inserting a bubble), squashes on branch flush, and keeps a
// saturating stall-cycle counter for performance debug.
//
// Ports:
//   Clk, reset            clock; asynchronous active-low reset
//   IFID_Rs/Rt/Rd         register fields of the instruction in ID
//   ReadData1/2           register-file read data for rs / rt
//   SignExtImm            sign-extended immediate
//   *_in, ALUOp_in        decoded control for the instruction in ID
//   WB_RegWrite/WriteReg/WriteData   writeback port (same as register file)
//   Flush                 squash the instruction entering EX
//   Stall                 load-use hazard (combinational)
//   PCWrite, IFIDWrite    upstream write enables (= ~Stall)
//   EX_*                  registered EX-stage state
//   StallCount            saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] IFID_Rs,
    input  logic [REG_AW-1:0] IFID_Rt,
    input  logic [REG_AW-1:0] IFID_Rd,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic              RegWrite_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              MemToReg_in,
    input  logic              ALUSrc_in,
    input  logic              RegDst_in,
    input  logic [3:0]        ALUOp_in,
    input  logic              WB_RegWrite,
    input  logic [REG_AW-1:0] WB_WriteReg,
    input  logic [DATA_W-1:0] WB_WriteData,
    input  logic              Flush,
    output logic              Stall,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              EX_Valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemToReg,
    output logic              EX_ALUSrc,
    output logic              EX_RegDst,
    output logic [3:0]        EX_ALUOp,
    output logic [DATA_W-1:0] EX_A,
    output logic [DATA_W-1:0] EX_B,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [REG_AW-1:0] EX_Rs,
    output logic [REG_AW-1:0] EX_Rt,
    output logic [REG_AW-1:0] EX_Rd,
    output logic [CNT_W-1:0]  StallCount
);

    // Per-read-port views so both operands share one bypass description.
    logic [REG_AW-1:0] srcReg [2];
    logic [DATA_W-1:0] rfData [2];
    logic [DATA_W-1:0] opNext [2];

    assign srcReg[0] = IFID_Rs;
    assign srcReg[1] = IFID_Rt;
    assign rfData[0] = ReadData1;
    assign rfData[1] = ReadData2;

    // The register file writes on the same edge that would capture its read
    // data, so a same-cycle writeback must be forwarded here. $zero is
    // hard-wired and never bypassed.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign opNext[gi] = (WB_RegWrite && (WB_WriteReg != '0) &&
                                 (WB_WriteReg == srcReg[gi]))
                                ? WB_WriteData : rfData[gi];
        end
    endgenerate

    // Load in EX whose destination is read by the instruction in ID. Both
    // source fields are compared regardless of format; a spurious stall only
    // costs one cycle.
    assign Stall = EX_Valid && EX_MemRead && (EX_Rt != '0) &&
                   ((EX_Rt == IFID_Rs) || (EX_Rt == IFID_Rt));

    assign PCWrite   = ~Stall;
    assign IFIDWrite = ~Stall;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            EX_Valid    <= 1'b0;
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_MemToReg <= 1'b0;
            EX_ALUSrc   <= 1'b0;
            EX_RegDst   <= 1'b0;
            EX_ALUOp    <= '0;
            EX_A        <= '0;
            EX_B        <= '0;
            EX_Imm      <= '0;
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_Rd       <= '0;
            StallCount  <= '0;
        end else begin
            if (Flush || Stall) begin
                // Bubble: a fully zeroed slot, so the forwarding unit and the
                // hazard check both see nothing in EX on the next cycle.
                EX_Valid    <= 1'b0;
                EX_RegWrite <= 1'b0;
                EX_MemRead  <= 1'b0;
                EX_MemWrite <= 1'b0;
                EX_MemToReg <= 1'b0;
                EX_ALUSrc   <= 1'b0;
                EX_RegDst   <= 1'b0;
                EX_ALUOp    <= '0;
                EX_A        <= '0;
                EX_B        <= '0;
                EX_Imm      <= '0;
                EX_Rs       <= '0;
                EX_Rt       <= '0;
                EX_Rd       <= '0;
            end else begin
                EX_Valid    <= 1'b1;
                EX_RegWrite <= RegWrite_in;
                EX_MemRead  <= MemRead_in;
                EX_MemWrite <= MemWrite_in;
                EX_MemToReg <= MemToReg_in;
                EX_ALUSrc   <= ALUSrc_in;
                EX_RegDst   <= RegDst_in;
                EX_ALUOp    <= ALUOp_in;
                EX_A        <= opNext[0];
                EX_B        <= opNext[1];
                EX_Imm      <= SignExtImm;
                EX_Rs       <= IFID_Rs;
                EX_Rt       <= IFID_Rt;
                EX_Rd       <= IFID_Rd;
            end

            // A flushed cycle is not charged to the load-use stall count.
            if (Stall && !Flush && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;   // narrow counter keeps the saturation run short

    localparam logic [5:0] C_LW    = 6'b110110; // RegWrite,MemRead,MemToReg,ALUSrc
    localparam logic [5:0] C_RTYPE = 6'b100001; // RegWrite,RegDst

    logic              Clk, reset;
    logic [REG_AW-1:0] IFID_Rs, IFID_Rt, IFID_Rd;
    logic [DATA_W-1:0] ReadData1, ReadData2, SignExtImm;
    logic              RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, RegDst_in;
    logic [3:0]        ALUOp_in;
    logic              WB_RegWrite;
    logic [REG_AW-1:0] WB_WriteReg;
    logic [DATA_W-1:0] WB_WriteData;
    logic              Flush;
    logic              Stall, PCWrite, IFIDWrite, EX_Valid;
    logic              EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst;
    logic [3:0]        EX_ALUOp;
    logic [DATA_W-1:0] EX_A, EX_B, EX_Imm;
    logic [REG_AW-1:0] EX_Rs, EX_Rt, EX_Rd;
    logic [CNT_W-1:0]  StallCount;

    int total_cnt = 0;
    int bad_cnt   = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .reset(reset),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_Rd(IFID_Rd),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtImm(SignExtImm),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .RegDst_in(RegDst_in),
        .ALUOp_in(ALUOp_in),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
        .Flush(Flush),
        .Stall(Stall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .EX_Valid(EX_Valid),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_ALUOp(EX_ALUOp), .EX_A(EX_A), .EX_B(EX_B), .EX_Imm(EX_Imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .StallCount(StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock: inputs are changed and outputs sampled on the falling edge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] imm, input logic [3:0] op, input logic [5:0] ctrl);
        IFID_Rs = rs; IFID_Rt = rt; IFID_Rd = rd;
        ReadData1 = rd1; ReadData2 = rd2; SignExtImm = imm; ALUOp_in = op;
        {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, RegDst_in} = ctrl;
    endtask

    initial begin
        reset = 1'b0; Flush = 1'b0;
        WB_RegWrite = 1'b0; WB_WriteReg = '0; WB_WriteData = '0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 6'b0);
        step();
        reset = 1'b1;
        #1;
        check_val("rst_valid", EX_Valid, 0);
        check_val("rst_cnt", StallCount, 0);
        check_val("rst_pcwrite", PCWrite, 1);
        check_val("rst_ifidwrite", IFIDWrite, 1);
        @(negedge Clk);

        // Normal capture
        set_instr(8, 9, 3, 32'h1, 32'h2, 32'h10, 4'd2, 6'b100000);
        step();
        check_val("cap_A", EX_A, 32'h1);
        check_val("cap_B", EX_B, 32'h2);
        check_val("cap_Imm", EX_Imm, 32'h10);
        check_val("cap_ALUOp", EX_ALUOp, 2);
        check_val("cap_Valid", EX_Valid, 1);
        check_val("cap_RegWrite", EX_RegWrite, 1);
        check_val("cap_Rs", EX_Rs, 8);
        check_val("cap_Rd", EX_Rd, 3);
        check_val("cap_Stall", Stall, 0);

        // Bypass rs
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd8; WB_WriteData = 32'hDEAD;
        set_instr(8, 9, 4, 32'h1, 32'h2, 32'h0, 4'd3, C_RTYPE);
        step();
        check_val("byp_rs_A", EX_A, 32'hDEAD);
        check_val("byp_rs_B", EX_B, 32'h2);
        check_val("byp_RegDst", EX_RegDst, 1);
        // Register 0 never bypassed
        WB_WriteReg = 5'd0;
        set_instr(0, 9, 4, 32'h1, 32'h2, 32'h0, 4'd3, C_RTYPE);
        step();
        check_val("byp_r0_A", EX_A, 32'h1);
        // Bypass rt
        WB_WriteReg = 5'd9; WB_WriteData = 32'hBEEF;
        set_instr(5, 9, 4, 32'h7, 32'h2, 32'h0, 4'd3, C_RTYPE);
        step();
        check_val("byp_rt_A", EX_A, 32'h7);
        check_val("byp_rt_B", EX_B, 32'hBEEF);
        // Writeback disabled: no bypass
        WB_RegWrite = 1'b0;
        step();
        check_val("byp_off_B", EX_B, 32'h2);

        // Load-use on rs
        set_instr(29, 10, 0, 32'd100, 32'd200, 32'd4, 4'd0, C_LW);
        step();
        check_val("lw_MemRead", EX_MemRead, 1);
        check_val("lw_Rt", EX_Rt, 10);
        check_val("lw_MemToReg", EX_MemToReg, 1);
        set_instr(10, 11, 12, 32'h3, 32'h4, 32'h0, 4'd2, C_RTYPE);
        #1;
        check_val("lu_Stall", Stall, 1);
        check_val("lu_PCWrite", PCWrite, 0);
        check_val("lu_IFIDWrite", IFIDWrite, 0);
        step();
        check_val("lu_bub_Valid", EX_Valid, 0);
        check_val("lu_bub_MemRead", EX_MemRead, 0);
        check_val("lu_bub_A", EX_A, 0);
        check_val("lu_bub_cnt", StallCount, 1);
        check_val("lu_bub_Stall", Stall, 0);
        step();
        check_val("lu_cap_Valid", EX_Valid, 1);
        check_val("lu_cap_Rs", EX_Rs, 10);
        check_val("lu_cap_A", EX_A, 32'h3);
        check_val("lu_cap_cnt", StallCount, 1);

        // Load-use on rt
        set_instr(29, 10, 0, 32'd100, 32'd200, 32'd4, 4'd0, C_LW);
        step();
        set_instr(5, 10, 6, 32'h5, 32'h6, 32'h0, 4'd2, C_RTYPE);
        #1;
        check_val("lu_rt_Stall", Stall, 1);
        step();
        check_val("lu_rt_cnt", StallCount, 2);
        step();
        check_val("lu_rt_cap_Rt", EX_Rt, 10);
        check_val("lu_rt_cap_B", EX_B, 32'h6);

        // Load into $zero never stalls
        set_instr(29, 0, 0, 32'd100, 32'd200, 32'd4, 4'd0, C_LW);
        step();
        set_instr(0, 0, 7, 32'h1, 32'h1, 32'h0, 4'd2, C_RTYPE);
        #1;
        check_val("lu_r0_Stall", Stall, 0);
        step();

        // Flush with concurrent hazard
        set_instr(29, 12, 0, 32'd100, 32'd200, 32'd4, 4'd0, C_LW);
        step();
        set_instr(12, 13, 14, 32'h9, 32'h8, 32'h7, 4'd2, C_RTYPE);
        Flush = 1'b1;
        #1;
        check_val("fl_Stall", Stall, 1);
        step();
        check_val("fl_Valid", EX_Valid, 0);
        check_val("fl_RegWrite", EX_RegWrite, 0);
        check_val("fl_MemRead", EX_MemRead, 0);
        check_val("fl_A", EX_A, 0);
        check_val("fl_Rs", EX_Rs, 0);
        check_val("fl_cnt", StallCount, 2);
        Flush = 1'b0;
        step();
        check_val("fl_after_Valid", EX_Valid, 1);
        check_val("fl_after_Rs", EX_Rs, 12);
        // Flush alone on a valid instruction
        Flush = 1'b1;
        step();
        check_val("fl2_Valid", EX_Valid, 0);
        check_val("fl2_Imm", EX_Imm, 0);
        Flush = 1'b0;

        // Asynchronous reset mid-operation
        set_instr(29, 10, 0, 32'd100, 32'd200, 32'd4, 4'd0, C_LW);
        step();
        set_instr(10, 11, 12, 32'h3, 32'h4, 32'h0, 4'd2, C_RTYPE);
        #1;
        check_val("mr_pre_Stall", Stall, 1);
        #2 reset = 1'b0;
        #1;
        check_val("mr_Valid", EX_Valid, 0);
        check_val("mr_MemRead", EX_MemRead, 0);
        check_val("mr_A", EX_A, 0);
        check_val("mr_cnt", StallCount, 0);
        check_val("mr_Stall", Stall, 0);
        check_val("mr_PCWrite", PCWrite, 1);
        @(negedge Clk);
        reset = 1'b1;

        // Saturation: lw $10 <- 0($10) held in ID stalls every other edge
        set_instr(10, 10, 0, 32'd1, 32'd2, 32'd0, 4'd0, C_LW);
        step();
        check_val("sat_first_Stall", Stall, 1);
        repeat (20) step();
        check_val("sat_cnt_10", StallCount, 10);
        repeat (2 * 249) step();
        check_val("sat_Stall_still", Stall, 1);
        check_val("sat_cnt_max", StallCount, 8'hFF);
        repeat (4) step();
        check_val("sat_cnt_hold", StallCount, 8'hFF);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
